// File: rtl/ncr5380_dma.sv
// NCR 5380-style SCSI initiator with a DMA byte FIFO.
// The host sees the classic 5380 register map plus two DMA count registers.
// An arbitration FSM drives AIP/LA, and a handshake FSM moves bytes between
// the FIFO and the selected target using REQ/ACK.
//
// Handshake semantics: every host access is a level strobe qualified by
// bus_cs (registers) or dack (DMA data). The rising edge of the strobe is the
// one and only transfer cycle. On the SCSI side, a byte moves on each
// REQ/ACK pair: REQ high -> ACK high -> REQ low -> ACK low.
module ncr5380_dma #(
    parameter int DEVS       = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    parameter int ARB_DLY    = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_cs,
    input  logic [3:0]        bus_rs,
    input  logic              ior,
    input  logic              iow,
    input  logic              dack,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    output logic              dreq,
    output logic              irq,
    input  logic [DEVS-1:0]   tgt_bsy,
    input  logic [DEVS-1:0]   tgt_msg,
    input  logic [DEVS-1:0]   tgt_cd,
    input  logic [DEVS-1:0]   tgt_io,
    input  logic [DEVS-1:0]   tgt_req,
    input  logic [8*DEVS-1:0] tgt_dout,
    output logic              scsi_rst,
    output logic              scsi_sel,
    output logic              scsi_atn,
    output logic              scsi_ack,
    output logic [7:0]        scsi_dout
);

    localparam int AW  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW  = AW + 1;
    localparam int ACW = (ARB_DLY > 1) ? $clog2(ARB_DLY + 1) : 1;

    typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_WON} arb_state_t;
    typedef enum logic [1:0] {H_IDLE, H_WAIT_REQ, H_ACK, H_WAIT_NREQ} hs_state_t;

    // Strobe edge detection
    logic reg_wr_q, reg_rd_q, dma_wr_q, dma_rd_q;
    logic reg_wr, reg_rd, dma_wr, dma_rd;

    // Registers
    logic [7:0] mr, tcr, odr;
    logic       icr_rst;
    logic [4:0] icr_lo;
    logic       mr0_q, rst_q;
    logic       la;

    // Target mux results
    logic       t_req, t_msg, t_cd, t_io;
    logic [7:0] t_data;
    logic       pmatch;

    // Arbitration
    arb_state_t     arb_state, arb_next;
    logic [ACW-1:0] arb_cnt;
    logic           aip;

    // DMA control
    logic             dma_en, dma_send, eodma;
    logic [CNT_W-1:0] dma_cnt;
    logic [15:0]      cnt16;
    logic             start, mr1_off;
    logic [7:0]       dma_rdata;

    // Handshake
    hs_state_t hs_state, hs_next;
    logic      hs_ack, hs_push, hs_pop, hs_dec, dec_last;

    // FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] fifo_level;
    logic          fifo_full, fifo_empty;
    logic          host_push, host_pop, fifo_push, fifo_pop, push_ok, pop_ok;
    logic [7:0]    push_data, fifo_head;
    logic          eodma_pending;

    // Interrupt
    logic irq_set, irq_clr, rx_drained, tx_done, mismatch, rst_rise;
    logic bus_drive;
    logic [7:0] icr_rd, csr, bsr;

    assign reg_wr = bus_cs & iow & ~reg_wr_q;
    assign reg_rd = bus_cs & ior & ~reg_rd_q;
    assign dma_wr = dack & iow & ~dma_wr_q;
    assign dma_rd = dack & ior & ~dma_rd_q;

    // Remember previous strobe levels so each access yields one pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_wr_q <= 1'b0;
            reg_rd_q <= 1'b0;
            dma_wr_q <= 1'b0;
            dma_rd_q <= 1'b0;
            mr0_q    <= 1'b0;
            rst_q    <= 1'b0;
        end else begin
            reg_wr_q <= bus_cs & iow;
            reg_rd_q <= bus_cs & ior;
            dma_wr_q <= dack & iow;
            dma_rd_q <= dack & ior;
            mr0_q    <= mr[0];
            rst_q    <= icr_rst;
        end
    end

    // Highest-index busy target owns phase, REQ and data
    always_comb begin
        t_req  = 1'b0;
        t_msg  = 1'b0;
        t_cd   = 1'b0;
        t_io   = 1'b0;
        t_data = 8'h55;
        for (int i = 0; i < DEVS; i++) begin
            if (tgt_bsy[i]) begin
                t_req  = tgt_req[i];
                t_msg  = tgt_msg[i];
                t_cd   = tgt_cd[i];
                t_io   = tgt_io[i];
                t_data = tgt_dout[8*i +: 8];
            end
        end
    end

    assign pmatch = (tcr[2:0] == {t_msg, t_cd, t_io});

    // Host-writable 5380 registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mr      <= 8'h00;
            tcr     <= 8'h00;
            odr     <= 8'h00;
            icr_rst <= 1'b0;
            icr_lo  <= 5'h00;
        end else if (reg_wr) begin
            case (bus_rs)
                4'd0: odr <= wdata;
                4'd1: begin
                    icr_rst <= wdata[7];
                    icr_lo  <= wdata[4:0];
                end
                4'd2: mr  <= wdata;
                4'd3: tcr <= wdata;
                default: ;
            endcase
        end
    end

    // Arbitration next state
    always_comb begin
        arb_next = arb_state;
        case (arb_state)
            ARB_IDLE: if (mr[0] && !mr0_q) arb_next = ARB_WAIT;
            ARB_WAIT: begin
                if (!mr[0])
                    arb_next = ARB_IDLE;
                else if (arb_cnt == ACW'(ARB_DLY - 1))
                    arb_next = ARB_WON;
            end
            ARB_WON:  if (!mr[0]) arb_next = ARB_IDLE;
            default:  arb_next = ARB_IDLE;
        endcase
    end

    // Arbitration state, delay counter and lost-arbitration flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arb_state <= ARB_IDLE;
            arb_cnt   <= '0;
            la        <= 1'b0;
        end else begin
            arb_state <= arb_next;
            arb_cnt   <= (arb_state == ARB_WAIT) ? arb_cnt + ACW'(1) : '0;
            if (arb_state == ARB_IDLE && arb_next == ARB_WAIT)
                la <= 1'b0;
            else if (arb_state == ARB_WAIT && |tgt_bsy)
                la <= 1'b1;
        end
    end

    assign aip = (arb_state == ARB_WON);

    // Clearing MR[1] takes effect in the cycle of the write itself
    assign mr1_off = (reg_wr && bus_rs == 4'd2) ? ~wdata[1] : ~mr[1];
    assign start   = reg_wr & mr[1] & ((bus_rs == 4'd5) | (bus_rs == 4'd7));
    assign cnt16   = 16'(dma_cnt);

    // DMA enable, direction, end-of-DMA flag and byte counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dma_en   <= 1'b0;
            dma_send <= 1'b0;
            eodma    <= 1'b0;
            dma_cnt  <= '0;
        end else begin
            if (mr1_off)
                dma_en <= 1'b0;
            else if (start) begin
                dma_en   <= 1'b1;
                dma_send <= (bus_rs == 4'd5);
            end
            if (start)
                eodma <= 1'b0;
            else if (dec_last)
                eodma <= 1'b1;
            if (reg_wr && bus_rs == 4'd8)
                dma_cnt <= CNT_W'({cnt16[15:8], wdata});
            else if (reg_wr && bus_rs == 4'd9)
                dma_cnt <= CNT_W'({wdata, cnt16[7:0]});
            else if (hs_dec && dma_cnt != '0)
                dma_cnt <= dma_cnt - CNT_W'(1);
        end
    end

    assign dec_last = hs_dec & (dma_cnt == CNT_W'(1));

    // Handshake next state and ACK/FIFO strobes
    always_comb begin
        hs_next = hs_state;
        hs_ack  = 1'b0;
        hs_push = 1'b0;
        hs_pop  = 1'b0;
        hs_dec  = 1'b0;
        case (hs_state)
            H_IDLE: if (dma_en && dma_cnt != '0) hs_next = H_WAIT_REQ;
            H_WAIT_REQ: begin
                if (!dma_en)
                    hs_next = H_IDLE;
                else if (t_req && pmatch && (dma_send ? !fifo_empty : !fifo_full))
                    hs_next = H_ACK;
            end
            H_ACK: begin
                hs_ack  = 1'b1;
                hs_push = dma_en & ~dma_send;
                hs_next = dma_en ? H_WAIT_NREQ : H_IDLE;
            end
            H_WAIT_NREQ: begin
                hs_ack = 1'b1;
                if (!dma_en)
                    hs_next = H_IDLE;
                else if (!t_req) begin
                    hs_next = H_IDLE;
                    hs_pop  = dma_send;
                    hs_dec  = 1'b1;
                end
            end
            default: hs_next = H_IDLE;
        endcase
    end

    // Handshake state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) hs_state <= H_IDLE;
        else       hs_state <= hs_next;
    end

    assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_level == '0);
    assign host_push  = dma_wr & dma_en & dma_send;
    assign host_pop   = dma_rd & dma_en & ~dma_send;
    assign fifo_push  = dma_send ? host_push : hs_push;
    assign fifo_pop   = dma_send ? hs_pop : host_pop;
    assign push_ok    = fifo_push & ~fifo_full;
    assign pop_ok     = fifo_pop & ~fifo_empty;
    assign push_data  = dma_send ? wdata : t_data;
    assign fifo_head  = mem[rd_ptr];

    // FIFO pointers and fill level; flushed whenever DMA mode is off
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (mr1_off) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)
                fifo_level <= fifo_level + LW'(1);
            else if (pop_ok && !push_ok)
                fifo_level <= fifo_level - LW'(1);
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_ok && !mr1_off)
            mem[wr_ptr] <= push_data;
    end

    // Byte returned to the host on a DMA read
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dma_rdata <= 8'h00;
        else if (host_pop && !fifo_empty)
            dma_rdata <= fifo_head;
    end

    // A send needs no more host bytes once the FIFO holds every remaining one
    assign eodma_pending = dma_send && (32'(fifo_level) >= 32'(dma_cnt));
    assign dreq = dma_en & (dma_send ? ~fifo_full : ~fifo_empty) & ~eodma_pending;

    assign tx_done    = dma_send & dec_last;
    assign rx_drained = ~dma_send & dma_en &
                        ((dec_last & fifo_empty) |
                         (host_pop & (fifo_level == LW'(1)) & (eodma | dec_last)));
    assign mismatch   = dma_en & t_req & ~pmatch;
    assign rst_rise   = icr_rst & ~rst_q;
    assign irq_set    = tx_done | rx_drained | mismatch | rst_rise;
    assign irq_clr    = reg_rd & (bus_rs == 4'd7);

    // Interrupt flag; a set in the same cycle as the clearing read wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        irq <= 1'b0;
        else if (irq_set) irq <= 1'b1;
        else if (irq_clr) irq <= 1'b0;
    end

    assign bus_drive = icr_lo[0] | mr[0];
    assign scsi_rst  = icr_rst;
    assign scsi_sel  = icr_lo[2];
    assign scsi_atn  = icr_lo[1];
    assign scsi_ack  = icr_lo[4] | hs_ack;
    assign scsi_dout = bus_drive ? ((dma_en & dma_send) ? fifo_head : odr) : 8'h00;

    assign icr_rd = {icr_rst, aip, la, icr_lo};
    assign csr    = {icr_rst, (|tgt_bsy) | icr_lo[3], t_req, t_msg, t_cd, t_io, icr_lo[2], 1'b0};
    assign bsr    = {eodma, dreq, 1'b0, irq, pmatch, 1'b0, icr_lo[1], scsi_ack};

    // Host read mux; DMA reads return the last popped byte
    always_comb begin
        rdata = 8'h00;
        if (dack)
            rdata = dma_rdata;
        else begin
            case (bus_rs)
                4'd0: rdata = bus_drive ? odr : t_data;
                4'd1: rdata = icr_rd;
                4'd2: rdata = mr;
                4'd3: rdata = tcr;
                4'd4: rdata = csr;
                4'd5: rdata = bsr;
                4'd6: rdata = t_data;
                4'd7: rdata = 8'hFF;
                4'd8: rdata = cnt16[7:0];
                4'd9: rdata = cnt16[15:8];
                default: rdata = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_ncr5380_dma.sv
// Directed bench for ncr5380_dma: register access, receive and send DMA,
// phase mismatch, arbitration and reset during a handshake.
module tb_ncr5380_dma;

    localparam int DEVS       = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 16;
    localparam int ARB_DLY    = 24;

    logic              clk = 1'b0;
    logic              reset;
    logic              bus_cs, ior, iow, dack;
    logic [3:0]        bus_rs;
    logic [7:0]        wdata, rdata;
    logic              dreq, irq;
    logic [DEVS-1:0]   tgt_bsy, tgt_msg, tgt_cd, tgt_io, tgt_req;
    logic [8*DEVS-1:0] tgt_dout;
    logic              scsi_rst, scsi_sel, scsi_atn, scsi_ack;
    logic [7:0]        scsi_dout;

    int n_assert = 0;
    int n_fail   = 0;

    ncr5380_dma #(
        .DEVS(DEVS), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .ARB_DLY(ARB_DLY)
    ) dut (
        .clk(clk), .reset(reset), .bus_cs(bus_cs), .bus_rs(bus_rs),
        .ior(ior), .iow(iow), .dack(dack), .wdata(wdata), .rdata(rdata),
        .dreq(dreq), .irq(irq), .tgt_bsy(tgt_bsy), .tgt_msg(tgt_msg),
        .tgt_cd(tgt_cd), .tgt_io(tgt_io), .tgt_req(tgt_req), .tgt_dout(tgt_dout),
        .scsi_rst(scsi_rst), .scsi_sel(scsi_sel), .scsi_atn(scsi_atn),
        .scsi_ack(scsi_ack), .scsi_dout(scsi_dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reg_wr(input logic [3:0] rs, input logic [7:0] d);
        @(negedge clk);
        bus_cs = 1'b1; bus_rs = rs; wdata = d; iow = 1'b1;
        @(negedge clk);
        iow = 1'b0; bus_cs = 1'b0;
    endtask

    task automatic reg_rd(input logic [3:0] rs, output logic [7:0] d);
        @(negedge clk);
        bus_cs = 1'b1; bus_rs = rs; ior = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        ior = 1'b0; bus_cs = 1'b0;
    endtask

    task automatic dma_wr(input logic [7:0] d);
        @(negedge clk);
        dack = 1'b1; iow = 1'b1; wdata = d;
        @(negedge clk);
        iow = 1'b0; dack = 1'b0;
    endtask

    task automatic dma_rd(output logic [7:0] d);
        @(negedge clk);
        dack = 1'b1; ior = 1'b1;
        @(negedge clk);
        d = rdata; ior = 1'b0; dack = 1'b0;
    endtask

    // Target 0 performs one REQ/ACK exchange; seen is scsi_dout during ACK
    task automatic tgt_xfer(input logic [7:0] d, output logic [7:0] seen, output logic ok);
        int n;
        ok = 1'b0; seen = 8'h00;
        @(negedge clk);
        tgt_dout[7:0] = d; tgt_req[0] = 1'b1;
        n = 0;
        while (scsi_ack !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (scsi_ack === 1'b1) begin ok = 1'b1; seen = scsi_dout; end
        tgt_req[0] = 1'b0;
        n = 0;
        while (scsi_ack !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        if (scsi_ack !== 1'b0) ok = 1'b0;
    endtask

    logic [7:0] rd, seen;
    logic       ok;
    logic [7:0] tx_bytes [5];
    int         acks;

    initial begin
        tx_bytes[0] = 8'h10; tx_bytes[1] = 8'h21; tx_bytes[2] = 8'h32;
        tx_bytes[3] = 8'h43; tx_bytes[4] = 8'h54;
        reset = 1'b1; bus_cs = 1'b0; bus_rs = 4'd2; ior = 1'b0; iow = 1'b0;
        dack = 1'b0; wdata = 8'h00;
        tgt_bsy = '0; tgt_msg = '0; tgt_cd = '0; tgt_io = '0; tgt_req = '0;
        tgt_dout = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dreq", dreq, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_ack", scsi_ack, 1'b0);
        check("rst_dout", scsi_dout, 8'h00);
        check("rst_rdata_mr", rdata, 8'h00);
        reset = 1'b0;
        @(negedge clk);

        // Register read-back
        reg_wr(4'd1, 8'h0C);
        reg_wr(4'd2, 8'h02);
        reg_wr(4'd3, 8'h03);
        reg_rd(4'd1, rd); check("icr_rb", rd, 8'h0C);
        reg_rd(4'd2, rd); check("mr_rb", rd, 8'h02);
        reg_rd(4'd3, rd); check("tcr_rb", rd, 8'h03);
        reg_rd(4'd4, rd); check("csr_bsy_sel", rd, 8'h42);
        reg_wr(4'd1, 8'h00);
        reg_wr(4'd2, 8'h00);

        // Target mux
        reg_rd(4'd6, rd); check("mux_idle", rd, 8'h55);
        tgt_dout = 16'h2211; tgt_bsy = 2'b11;
        reg_rd(4'd6, rd); check("mux_hi", rd, 8'h22);
        tgt_bsy = 2'b01;
        reg_rd(4'd6, rd); check("mux_lo", rd, 8'h11);

        // Initiator receive of three bytes
        tgt_io = 2'b01;
        reg_wr(4'd3, 8'h01);
        reg_wr(4'd2, 8'h02);
        reg_wr(4'd8, 8'h03);
        reg_wr(4'd9, 8'h00);
        reg_wr(4'd7, 8'h00);
        check("rx_dreq_empty", dreq, 1'b0);
        tgt_xfer(8'hA1, seen, ok); check("rx_ack0", ok, 1'b1);
        tgt_xfer(8'hB2, seen, ok); check("rx_ack1", ok, 1'b1);
        tgt_xfer(8'hC3, seen, ok); check("rx_ack2", ok, 1'b1);
        check("rx_irq_undrained", irq, 1'b0);
        reg_rd(4'd5, rd); check("rx_bsr_full", rd, 8'hC8);
        dma_rd(rd); check("rx_data0", rd, 8'hA1);
        dma_rd(rd); check("rx_data1", rd, 8'hB2);
        dma_rd(rd); check("rx_data2", rd, 8'hC3);
        @(negedge clk);
        check("rx_irq", irq, 1'b1);
        reg_rd(4'd5, rd); check("rx_bsr_done", rd, 8'h98);
        reg_rd(4'd8, rd); check("rx_cnt_lo", rd, 8'h00);
        reg_rd(4'd9, rd); check("rx_cnt_hi", rd, 8'h00);
        reg_rd(4'd7, rd); check("rx_r7", rd, 8'hFF);
        @(negedge clk);
        check("rx_irq_clr", irq, 1'b0);
        reg_wr(4'd2, 8'h00);
        tgt_io = 2'b00;

        // Send of five bytes through a four-entry FIFO
        reg_wr(4'd1, 8'h01);
        reg_wr(4'd3, 8'h00);
        reg_wr(4'd2, 8'h02);
        reg_wr(4'd8, 8'h05);
        reg_wr(4'd9, 8'h00);
        reg_wr(4'd5, 8'h00);
        check("tx_dreq_start", dreq, 1'b1);
        for (int i = 0; i < 4; i++) dma_wr(tx_bytes[i]);
        check("tx_dreq_full", dreq, 1'b0);
        tgt_xfer(8'h00, seen, ok);
        check("tx_ack0", ok, 1'b1);
        check("tx_byte0", seen, tx_bytes[0]);
        check("tx_dreq_after_pop", dreq, 1'b1);
        dma_wr(tx_bytes[4]);
        check("tx_dreq_all_queued", dreq, 1'b0);
        for (int i = 1; i < 5; i++) begin
            if (i == 4) check("tx_irq_before_last", irq, 1'b0);
            tgt_xfer(8'h00, seen, ok);
            check("tx_ack", ok, 1'b1);
            check("tx_byte", seen, tx_bytes[i]);
        end
        check("tx_irq", irq, 1'b1);
        reg_rd(4'd8, rd); check("tx_cnt_lo", rd, 8'h00);
        reg_rd(4'd7, rd);
        reg_wr(4'd2, 8'h00);
        reg_wr(4'd1, 8'h00);

        // Phase mismatch: status phase while TCR says data-out
        reg_wr(4'd1, 8'h01);
        reg_wr(4'd3, 8'h00);
        reg_wr(4'd2, 8'h02);
        reg_wr(4'd8, 8'h01);
        reg_wr(4'd5, 8'h00);
        dma_wr(8'h77);
        @(negedge clk);
        tgt_cd = 2'b01; tgt_io = 2'b01; tgt_req = 2'b01;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (scsi_ack === 1'b1) acks++;
        end
        check("pm_no_ack", acks, 0);
        check("pm_irq", irq, 1'b1);
        tgt_req = 2'b00;
        @(negedge clk);
        reg_rd(4'd7, rd); check("pm_r7", rd, 8'hFF);
        @(negedge clk);
        check("pm_irq_clr", irq, 1'b0);
        reg_wr(4'd2, 8'h00);
        reg_wr(4'd1, 8'h00);
        tgt_cd = 2'b00; tgt_io = 2'b00; tgt_bsy = 2'b00;

        // Arbitration without and with a competing BSY
        reg_wr(4'd2, 8'h01);
        reg_rd(4'd1, rd); check("arb_wait", rd, 8'h00);
        repeat (ARB_DLY + 4) @(negedge clk);
        reg_rd(4'd1, rd); check("arb_won", rd, 8'h40);
        reg_wr(4'd2, 8'h00);
        reg_wr(4'd2, 8'h01);
        @(negedge clk);
        tgt_bsy = 2'b01;
        @(negedge clk);
        tgt_bsy = 2'b00;
        repeat (ARB_DLY + 4) @(negedge clk);
        reg_rd(4'd1, rd); check("arb_lost", rd, 8'h60);
        reg_wr(4'd2, 8'h00);

        // Reset while the handshake waits for REQ to drop
        tgt_bsy = 2'b01;
        reg_wr(4'd1, 8'h01);
        reg_wr(4'd2, 8'h02);
        reg_wr(4'd8, 8'h02);
        reg_wr(4'd5, 8'h00);
        dma_wr(8'hAA);
        @(negedge clk);
        tgt_req = 2'b01;
        acks = 0;
        while (scsi_ack !== 1'b1 && acks < 50) begin @(negedge clk); acks++; end
        check("hr_ack_seen", scsi_ack, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1 check("hr_ack_drop", scsi_ack, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        tgt_req = 2'b00;
        reg_rd(4'd8, rd); check("hr_cnt_lo", rd, 8'h00);
        reg_rd(4'd9, rd); check("hr_cnt_hi", rd, 8'h00);
        reg_wr(4'd2, 8'h02);
        reg_wr(4'd8, 8'h01);
        reg_wr(4'd7, 8'h00);
        check("hr_fifo_empty", dreq, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ncr5380_dma.md
NCR5380_DMA -- requirements
Module: ncr5380_dma

Interface
REQ-001 Parameter DEVS, default 2, number of attached targets (1..7).
REQ-002 Parameter FIFO_DEPTH, default 4, DMA data FIFO entries (power of two, 2..16).
REQ-003 Parameter CNT_W, default 16, width of the DMA byte counter.
REQ-004 Parameter ARB_DLY, default 24, arbitration delay in clk cycles.
REQ-005 clk  in  1  system clock; reset reset, asynchronous, active-high; clock clk.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 bus_cs  in  1  chip select; bus_rs  in  4  register select (0-7 standard 5380 map, 8 = count low byte, 9 = count high byte).
REQ-008 ior / iow  in  1  host read / write strobes; dack  in  1  DMA acknowledge.
REQ-009 wdata  in  8  host write data; rdata  out  8  host read data (combinational mux).
REQ-010 dreq  out  1  DMA request; irq  out  1  interrupt request.
REQ-011 tgt_bsy, tgt_msg, tgt_cd, tgt_io, tgt_req  in  DEVS  per-target SCSI signals; tgt_dout  in  8*DEVS  per-target data, target i at bits [8i+7:8i].
REQ-012 scsi_rst, scsi_sel, scsi_atn, scsi_ack  out  1  initiator SCSI signals; scsi_dout  out  8  initiator data.

Function
REQ-013 Host strobes are edge-detected; each rising edge of (bus_cs & iow) or (bus_cs & ior) produces exactly one single-cycle internal pulse.
REQ-014 Target mux: the highest-index target with tgt_bsy set drives phase, REQ and data; with no target busy, phase/REQ = 0 and data = 8'h55.
REQ-015 Registers MR, ICR and TCR follow the 5380 map; CSR = {rst, bsy, req, msg, cd, io, sel, 0}.
REQ-016 BSR = {eodma, dmarq, 0, irq, pmatch, 0, atn, ack}; pmatch = TCR[2:0] equals {msg, cd, io}.
REQ-017 Count registers 8/9 load CNT_W-bit dma_cnt; reads return the live count, bits above CNT_W read 0.
REQ-018 Arbitration FSM: ARB_IDLE -> ARB_WAIT on MR[0] rising; after ARB_DLY cycles -> ARB_WON (ICR AIP = 1); any tgt_bsy during ARB_WAIT sets LA (ICR bit 5); MR[0] cleared -> ARB_IDLE in the next cycle.
REQ-019 A write to register 5 (send) or 7 (initiator receive) while MR[1] = 1 sets dma_en, records direction and clears eodma; clearing MR[1] clears dma_en and flushes the FIFO in the same cycle.
REQ-020 Handshake FSM states: H_IDLE, H_WAIT_REQ, H_ACK, H_WAIT_NREQ.
REQ-021 H_IDLE -> H_WAIT_REQ when dma_en and dma_cnt != 0.
REQ-022 H_WAIT_REQ -> H_ACK when REQ = 1 and pmatch, with the FIFO non-empty for send or non-full for receive.
REQ-023 In H_ACK, scsi_ack = 1: receive pushes the target data; send already presents the FIFO head on scsi_dout.
REQ-024 H_ACK -> H_WAIT_NREQ after one cycle, with scsi_ack held; H_WAIT_NREQ -> H_IDLE on REQ = 0, deasserting ack, popping the FIFO on send and decrementing dma_cnt.
REQ-025 dreq = dma_en & (send ? FIFO not full : FIFO not empty) & ~eodma_pending; host DMA writes push wdata and DMA reads pop to rdata.
REQ-026 FIFO boundary behaviour: push when full and pop when empty are ignored; simultaneous push and pop keeps the level unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-027 When dma_cnt reaches 0, eodma sets.
REQ-028 eodma also raises irq once the FIFO has drained: send at the last ACK, receive after the host's last read.
REQ-029 irq also sets on phase mismatch (REQ = 1, ~pmatch, dma_en) and on scsi_rst rising.
REQ-030 irq clears on a host read of register 7, returning 8'hFF; a simultaneous set wins.
REQ-031 scsi_ack = ICR[4] | handshake ack; scsi_dout = dma send active ? FIFO head : ODR.
REQ-032 Bus drive: scsi_dout is valid only when ICR[0] | MR[0]; CDR reads loop back ODR when asserting the bus, else return target data.

Reset
REQ-033 Asynchronous reset clears MR, ICR, TCR, ODR, dma_cnt, dma_en, eodma and irq, empties the FIFO, and forces both FSMs to idle.
REQ-034 On reset, all outputs go to 0 except rdata, which reflects the cleared registers.
REQ-035 Reset mid-handshake drops scsi_ack within the reset assertion, with no count decrement.

Verification
REQ-036 Register read-back: write ICR = 0x0C, MR = 0x02, TCR = 0x03 -> reads return ICR 0x0C, MR 0x02, TCR 0x03 exactly.
REQ-037 Initiator receive: count = 3, target in data-in phase supplies 0xA1, 0xB2, 0xC3 -> three ACK cycles; host DMA reads return A1, B2, C3; eodma = 1; irq = 1; dma_cnt = 0.
REQ-038 Send with FIFO fill: count = 5, FIFO_DEPTH = 4, host pushes 5 bytes -> dreq low after 4 pushes until the first ACK pop; target receives all 5 bytes in order.
REQ-039 Phase mismatch: TCR = data-out, target switches to status phase (cd = 1, io = 1) with REQ -> no ACK; irq = 1; register 7 read clears irq.
REQ-040 Arbitration: MR[0] set, no target busy for ARB_DLY cycles -> AIP = 1, LA = 0; repeat with tgt_bsy[0] pulsed -> LA = 1.
REQ-041 Reset during H_WAIT_NREQ -> scsi_ack = 0 on reset; dma_cnt = 0 and FIFO empty after release.
